// File: rtl/ps_input_arbiter.sv
// Two-requester round-robin merge arbiter feeding the PS stage over four-phase Send/Ack.
// A one-entry buffer decouples the input-side handshake from the output-side handshake.
module ps_input_arbiter #(
  parameter int PKT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic             Send_in0,
  input  logic [PKT_W-1:0] PACKET_IN0,
  output logic             Ack_out0,
  input  logic             Send_in1,
  input  logic [PKT_W-1:0] PACKET_IN1,
  output logic             Ack_out1,
  output logic             Send_out,
  output logic [PKT_W-1:0] PACKET_OUT,
  input  logic             Ack_in,
  output logic [CNT_W-1:0] PKT_CNT
);

  localparam logic       I_IDLE = 1'b0;
  localparam logic       I_ACK  = 1'b1;
  localparam logic [1:0] O_IDLE = 2'd0;
  localparam logic [1:0] O_REQ  = 2'd1;
  localparam logic [1:0] O_RTZ  = 2'd2;

  logic             in_state;
  logic             g;
  logic             rr;
  logic [PKT_W-1:0] buf_q;
  logic             full;
  logic [1:0]       out_state;

  logic grant;
  logic grant_idx;
  logic out_done;
  logic g_send;

  always_comb begin
    grant     = (in_state == I_IDLE) && !full && (Send_in0 || Send_in1);
    grant_idx = (Send_in0 && Send_in1) ? rr : Send_in1;
    out_done  = (out_state == O_REQ) && Ack_in;
    g_send    = g ? Send_in1 : Send_in0;
  end

  // Input side: capture into the buffer only when it was empty at this edge.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      in_state <= I_IDLE;
      g        <= 1'b0;
      rr       <= 1'b0;
      buf_q    <= '0;
      Ack_out0 <= 1'b0;
      Ack_out1 <= 1'b0;
    end else if (in_state == I_IDLE) begin
      if (grant) begin
        buf_q    <= grant_idx ? PACKET_IN1 : PACKET_IN0;
        g        <= grant_idx;
        rr       <= ~grant_idx;
        Ack_out0 <= ~grant_idx;
        Ack_out1 <= grant_idx;
        in_state <= I_ACK;
      end
    end else begin
      if (!g_send) begin
        Ack_out0 <= 1'b0;
        Ack_out1 <= 1'b0;
        in_state <= I_IDLE;
      end
    end
  end

  // Set and clear can never coincide: a grant needs full=0, a completion needs full=1.
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      full <= 1'b0;
    end else if (grant) begin
      full <= 1'b1;
    end else if (out_done) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      out_state <= O_IDLE;
      Send_out  <= 1'b0;
      PKT_CNT   <= '0;
    end else begin
      case (out_state)
        O_IDLE: begin
          if (full) begin
            Send_out  <= 1'b1;
            out_state <= O_REQ;
          end
        end
        O_REQ: begin
          if (Ack_in) begin
            Send_out  <= 1'b0;
            PKT_CNT   <= PKT_CNT + CNT_W'(1);
            out_state <= O_RTZ;
          end
        end
        O_RTZ: begin
          if (!Ack_in) out_state <= O_IDLE;
        end
        default: out_state <= O_IDLE;
      endcase
    end
  end

  assign PACKET_OUT = buf_q;

endmodule

// File: tb/tb_ps_input_arbiter.sv
// Scoreboard bench for ps_input_arbiter: stimulus queues expected packets, a monitor
// compares every completed output handshake; a second instance with CNT_W=2 shows the wrap.
module tb_ps_input_arbiter;

  logic        CLK = 1'b0;
  logic        MR = 1'b0;
  logic        Send_in0 = 1'b0;
  logic [31:0] PACKET_IN0 = '0;
  logic        Ack_out0;
  logic        Send_in1 = 1'b0;
  logic [31:0] PACKET_IN1 = '0;
  logic        Ack_out1;
  logic        Send_out;
  logic [31:0] PACKET_OUT;
  logic        Ack_in = 1'b0;
  logic [15:0] PKT_CNT;

  logic        w_ack0, w_ack1, w_send;
  logic [31:0] w_pkt;
  logic [1:0]  w_cnt;

  ps_input_arbiter #(.PKT_W(32), .CNT_W(16)) dut (
    .CLK(CLK), .MR(MR),
    .Send_in0(Send_in0), .PACKET_IN0(PACKET_IN0), .Ack_out0(Ack_out0),
    .Send_in1(Send_in1), .PACKET_IN1(PACKET_IN1), .Ack_out1(Ack_out1),
    .Send_out(Send_out), .PACKET_OUT(PACKET_OUT), .Ack_in(Ack_in),
    .PKT_CNT(PKT_CNT)
  );

  ps_input_arbiter #(.PKT_W(32), .CNT_W(2)) dut_wrap (
    .CLK(CLK), .MR(MR),
    .Send_in0(Send_in0), .PACKET_IN0(PACKET_IN0), .Ack_out0(w_ack0),
    .Send_in1(Send_in1), .PACKET_IN1(PACKET_IN1), .Ack_out1(w_ack1),
    .Send_out(w_send), .PACKET_OUT(w_pkt), .Ack_in(Ack_in),
    .PKT_CNT(w_cnt)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic        prev_send = 1'b0;
  logic        ps_auto = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: a falling Send_out outside reset marks a completed output handshake.
  initial begin
    forever begin
      @(negedge CLK);
      if (!MR) begin
        exp_cnt   = '0;
        prev_send = 1'b0;
      end else begin
        if (prev_send && !Send_out) begin
          exp_cnt = exp_cnt + 16'd1;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_packet: got %0h expected none", PACKET_OUT);
          end else begin
            check("pkt_out", {32'd0, PACKET_OUT}, {32'd0, exp_q.pop_front()});
          end
          check("pkt_cnt", {48'd0, PKT_CNT}, {48'd0, exp_cnt});
          check("wrap_cnt", {62'd0, w_cnt}, {62'd0, exp_cnt[1:0]});
        end
        prev_send = Send_out;
      end
    end
  end

  // Zero-latency PS stage model
  initial begin
    forever begin
      @(negedge CLK);
      if (ps_auto && MR) begin
        if (Send_out && !Ack_in) Ack_in = 1'b1;
        else if (!Send_out && Ack_in) Ack_in = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  function automatic logic ack_of(input int k);
    return (k == 0) ? Ack_out0 : Ack_out1;
  endfunction

  task automatic set_send(input int k, input logic v, input logic [31:0] pkt);
    if (k == 0) begin Send_in0 = v; PACKET_IN0 = pkt; end
    else begin Send_in1 = v; PACKET_IN1 = pkt; end
  endtask

  // Full four-phase transaction on one input port; called at a negedge.
  task automatic req(input int k, input logic [31:0] pkt);
    int t;
    set_send(k, 1'b1, pkt);
    t = 0;
    do begin @(negedge CLK); t++; end while (ack_of(k) !== 1'b1 && t < 300);
    check(k == 0 ? "req0_ack_timeout" : "req1_ack_timeout", {63'd0, t >= 300}, 64'd0);
    set_send(k, 1'b0, pkt);
    t = 0;
    do begin @(negedge CLK); t++; end while (ack_of(k) !== 1'b0 && t < 300);
    check(k == 0 ? "req0_rtz_timeout" : "req1_rtz_timeout", {63'd0, t >= 300}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    MR = 1'b0; Send_in0 = 1'b0; Send_in1 = 1'b0; Ack_in = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    MR = 1'b1;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || Send_out || Ack_in) && t < 400) begin
      @(negedge CLK); t++;
    end
    check(name, {63'd0, t >= 400}, 64'd0);
  endtask

  int   bad_send, bad_pkt, bad_ack1;
  logic early1, seen_done, was_send;

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_ack0", {63'd0, Ack_out0}, 64'd0);
    check("rst_ack1", {63'd0, Ack_out1}, 64'd0);
    check("rst_send", {63'd0, Send_out}, 64'd0);
    check("rst_pkt", {32'd0, PACKET_OUT}, 64'd0);
    check("rst_cnt", {48'd0, PKT_CNT}, 64'd0);
    MR = 1'b1;

    // Single packet, manual PS acknowledge
    exp_q.push_back(32'hA5A5_0001);
    Send_in0 = 1'b1; PACKET_IN0 = 32'hA5A5_0001;
    @(negedge CLK);
    check("single_ack0_e1", {63'd0, Ack_out0}, 64'd1);
    check("single_send_e1", {63'd0, Send_out}, 64'd0);
    Send_in0 = 1'b0;
    @(negedge CLK);
    check("single_send_e2", {63'd0, Send_out}, 64'd1);
    check("single_pkt_e2", {32'd0, PACKET_OUT}, 64'hA5A5_0001);
    check("single_ack0_e2", {63'd0, Ack_out0}, 64'd0);
    @(negedge CLK);
    Ack_in = 1'b1;
    @(negedge CLK);
    check("single_send_e4", {63'd0, Send_out}, 64'd0);
    check("single_cnt_e4", {48'd0, PKT_CNT}, 64'd1);
    Ack_in = 1'b0;
    repeat (2) @(negedge CLK);

    // Simultaneous requests with rr=0
    do_reset();
    ps_auto = 1'b1;
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h20);
    early1 = 1'b0; seen_done = 1'b0; was_send = 1'b0;
    fork
      req(0, 32'h10);
      req(1, 32'h20);
      begin
        repeat (40) begin
          @(negedge CLK);
          if (Ack_out1 && !seen_done) early1 = 1'b1;
          if (was_send && !Send_out) seen_done = 1'b1;
          was_send = Send_out;
        end
      end
    join
    drain("simul_drain_timeout");
    check("simul_ack1_early", {63'd0, early1}, 64'd0);

    // Fairness: 8 packets alternate 0,1,0,1,...
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h100 + i);
      exp_q.push_back(32'h200 + i);
    end
    fork
      begin for (int i = 0; i < 4; i++) req(0, 32'h100 + i); end
      begin for (int j = 0; j < 4; j++) req(1, 32'h200 + j); end
    join
    drain("fair_drain_timeout");
    check("fair_cnt", {48'd0, PKT_CNT}, 64'd8);

    // Backpressure: PS holds off for 20 cycles
    ps_auto = 1'b0;
    exp_q.push_back(32'hBEEF_0000);
    exp_q.push_back(32'hCAFE_0001);
    req(0, 32'hBEEF_0000);
    bad_send = 0; bad_pkt = 0; bad_ack1 = 0;
    fork
      req(1, 32'hCAFE_0001);
      begin
        repeat (20) begin
          @(negedge CLK);
          if (Send_out !== 1'b1) bad_send++;
          if (PACKET_OUT !== 32'hBEEF_0000) bad_pkt++;
          if (Ack_out1 !== 1'b0) bad_ack1++;
        end
        ps_auto = 1'b1;
      end
    join
    check("bp_send_hold", bad_send, 0);
    check("bp_pkt_stable", bad_pkt, 0);
    check("bp_ack1_low", bad_ack1, 0);
    drain("bp_drain_timeout");
    check("bp_cnt", {48'd0, PKT_CNT}, 64'd10);

    // Reset while in O_REQ
    ps_auto = 1'b0;
    exp_q.push_back(32'h1234);
    req(0, 32'h1234);
    begin
      int t;
      t = 0;
      while (Send_out !== 1'b1 && t < 50) begin @(negedge CLK); t++; end
      check("mr_reach_oreq", {63'd0, t >= 50}, 64'd0);
    end
    #2;
    exp_q.delete();
    MR = 1'b0;
    #1;
    check("mr_send", {63'd0, Send_out}, 64'd0);
    check("mr_ack0", {63'd0, Ack_out0}, 64'd0);
    check("mr_ack1", {63'd0, Ack_out1}, 64'd0);
    check("mr_pkt", {32'd0, PACKET_OUT}, 64'd0);
    check("mr_cnt", {48'd0, PKT_CNT}, 64'd0);
    repeat (2) @(negedge CLK);
    MR = 1'b1;
    ps_auto = 1'b1;
    exp_q.push_back(32'h5678);
    req(0, 32'h5678);
    drain("mr_drain_timeout");
    check("mr_cnt_restart", {48'd0, PKT_CNT}, 64'd1);

    // Counter wrap on the CNT_W=2 instance: 1,2,3,0,1
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h900 + i);
    for (int i = 0; i < 5; i++) req(0, 32'h900 + i);
    drain("wrap_drain_timeout");
    check("wrap_final", {62'd0, w_cnt}, 64'd1);

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps_input_arbiter.md
# ps_input_arbiter

Clocked two-requester merge arbiter in front of the PS stage. It accepts packets from two upstream sources, the external input port (requester 0) and the internal return path (requester 1). It forwards them one at a time over the Send/Ack four-phase handshake that the PS stage consumes. Round-robin grant guarantees neither source starves, and a one-entry buffer decouples the input-side and output-side handshakes.

## Interface
Parameters:
- PKT_W, 32: packet width, equal to the PS stage input packet width.
- CNT_W, 16: width of the forwarded-packet counter.

Ports:
- CLK  in  1  clock, rising edge.
- MR  in  1  master reset, asynchronous, active-low.
- Send_in0  in  1  request from requester 0.
- PACKET_IN0  in  PKT_W  packet from requester 0, stable while Send_in0=1.
- Ack_out0  out  1  acknowledge to requester 0.
- Send_in1  in  1  request from requester 1.
- PACKET_IN1  in  PKT_W  packet from requester 1, stable while Send_in1=1.
- Ack_out1  out  1  acknowledge to requester 1.
- Send_out  out  1  request to the PS stage.
- PACKET_OUT  out  PKT_W  buffered packet, stable while Send_out=1.
- Ack_in  in  1  acknowledge from the PS stage.
- PKT_CNT  out  CNT_W  count of completed output handshakes, wraps.

## Operation
- All handshake inputs are synchronous to CLK; synchronizers live outside this block.
- Four-phase protocol on every port, in this order:
  1. Send rises, with data valid.
  2. Ack rises.
  3. Send falls.
  4. Ack falls.
- State held:
  - input FSM {I_IDLE, I_ACK};
  - grant index g;
  - round-robin pointer rr (the favoured requester);
  - buffer BUF[PKT_W] with a full flag;
  - output FSM {O_IDLE, O_REQ, O_RTZ};
  - PKT_CNT.
- Input FSM:
  - I_IDLE and full=0:
    - If exactly one Send_inK=1, grant K.
    - If both are 1, grant rr.
    - On grant: BUF<=PACKET_INK, full<=1, Ack_outK<=1, g<=K, rr<=~K, go to I_ACK.
  - I_IDLE and full=1: no grant. Requests wait; Ack_out0 and Ack_out1 stay 0.
  - I_ACK: when Send_in{g}=0 is sampled, Ack_out{g}<=0 and go to I_IDLE. Otherwise hold.
  - A request withdrawn before it is granted is simply never granted. No error flag.
  - The non-granted requester's Ack stays 0 throughout.
- Output FSM:
  - O_IDLE and full=1: Send_out<=1, go to O_REQ. PACKET_OUT is driven from BUF.
  - O_REQ and Ack_in=1: Send_out<=0, full<=0, PKT_CNT<=PKT_CNT+1 (mod 2^CNT_W), go to O_RTZ.
  - O_RTZ and Ack_in=0: go to O_IDLE.
- Grant condition: the input FSM tests full as sampled at the edge. A buffer freed at edge N is available for capture at edge N+1, never at the same edge.
- The input FSM may sit in I_ACK while the output FSM forwards the same packet. The two FSMs are independent.
- Ack_in=1 while in O_IDLE or O_RTZ (stale or spurious) is ignored, apart from holding O_RTZ.

## Timing
- Reset (MR=0, immediate):
  - Ack_out0=Ack_out1=Send_out=0;
  - PACKET_OUT=0, BUF=0, full=0;
  - PKT_CNT=0, rr=0, g=0;
  - FSMs in I_IDLE/O_IDLE.
- Reset asserted mid-handshake abandons any packet in flight. After release, the block restarts from idle and counts nothing for that packet.
- Send_inK first sampled 1 at edge N, with the buffer empty:
  - Ack_outK=1 after edge N.
  - full=1 after edge N.
  - Send_out=1 after edge N+1.
- Ack_in sampled 1 at edge M: Send_out=0 and PKT_CNT incremented after edge M.
- Earliest next grant is edge M+1.
- Throughput: at most one packet per four-phase output handshake. Minimum 3 cycles per packet at a zero-latency PS stage.
- PACKET_OUT changes only on a capture edge. It is stable whenever Send_out=1.

## Test plan
- Single packet: Send_in0=1 with PACKET_IN0=32'hA5A5_0001 at edge 1 → Ack_out0=1 after edge 1, Send_out=1 after edge 2 with PACKET_OUT=32'hA5A5_0001. Ack_in=1 at edge 4 → Send_out=0 and PKT_CNT=1.
- Simultaneous requests after reset (rr=0): both Send_in raised with packets 0x10 and 0x20 → 0x10 is forwarded first and Ack_out1 stays 0. 0x20 is forwarded next, with its Ack_out1 rising no earlier than the edge after the first Ack_in.
- Fairness: both requesters hold continuous requests for 8 packets → output sequence alternates 0,1,0,1,… and PKT_CNT=8.
- Backpressure: Ack_in held 0 for 20 cycles with the buffer full → Send_out holds 1, PACKET_OUT is stable, and a second requester's Ack stays 0 throughout.
- Reset mid-operation: MR=0 while in O_REQ → all outputs read 0 at once. After release, a new packet is accepted normally and PKT_CNT restarts from 1.
- Wrap: CNT_W=2, five completed packets → PKT_CNT reads 1,2,3,0,1.
